// File: rtl/cache_pkg.sv
// Shared types and constants for the cache/memory arbiter.
package cache_pkg;

   localparam int LINE_W_DEF = 128;
   localparam int LINE_OFF   = 4;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_e;
   typedef enum logic {OWN_IC, OWN_DC} owner_e;

   function automatic logic [31:0] line_align(input logic [31:0] addr);
      return addr & ~((32'd1 << LINE_OFF) - 32'd1);
   endfunction

endpackage

// File: rtl/cache_mem_arbiter.sv
// Shares one main-memory line port between icache refills and dcache refills/writebacks.
//   state | meaning
//   IDLE  | sample requests, round-robin pick on a tie
//   BUSY  | mem_req_o high, waiting for mem_ack_i or watchdog expiry
//   RESP  | one-cycle ack (and err on timeout) to the owner
module cache_mem_arbiter
   import cache_pkg::*;
#(
   parameter int LINE_W  = LINE_W_DEF,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              ic_req_i,
   input  logic [31:0]       ic_addr_i,
   output logic              ic_ack_o,
   output logic [LINE_W-1:0] ic_rdata_o,
   output logic              ic_err_o,
   input  logic              dc_req_i,
   input  logic              dc_we_i,
   input  logic [31:0]       dc_addr_i,
   input  logic [LINE_W-1:0] dc_wdata_i,
   output logic              dc_ack_o,
   output logic [LINE_W-1:0] dc_rdata_o,
   output logic              dc_err_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [31:0]       mem_addr_o,
   output logic [LINE_W-1:0] mem_wdata_o,
   input  logic              mem_ack_i,
   input  logic [LINE_W-1:0] mem_rdata_i,
   output logic              busy_o
);

   localparam int CNT_W = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   arb_state_e        state_q, state_d;
   owner_e            owner_q, owner_d;
   owner_e            last_q, last_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [31:0]       mem_addr_q, mem_addr_d;
   logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              ic_ack_q, ic_ack_d, ic_err_q, ic_err_d;
   logic              dc_ack_q, dc_ack_d, dc_err_q, dc_err_d;
   logic [LINE_W-1:0] ic_rdata_q, ic_rdata_d, dc_rdata_q, dc_rdata_d;
   logic              busy_q, busy_d;
   logic              grant_dc;
   logic              timed_out;
   logic [LINE_W-1:0] line;

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      last_d      = last_q;
      cnt_d       = cnt_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      ic_ack_d    = 1'b0;
      ic_err_d    = 1'b0;
      dc_ack_d    = 1'b0;
      dc_err_d    = 1'b0;
      ic_rdata_d  = ic_rdata_q;
      dc_rdata_d  = dc_rdata_q;
      busy_d      = busy_q;
      grant_dc    = 1'b0;
      timed_out   = 1'b0;
      line        = '0;

      case (state_q)
         IDLE: begin
            if (ic_req_i || dc_req_i) begin
               // On a tie the requester that was not granted last wins.
               grant_dc    = dc_req_i && (!ic_req_i || last_q == OWN_IC);
               owner_d     = grant_dc ? OWN_DC : OWN_IC;
               last_d      = grant_dc ? OWN_DC : OWN_IC;
               mem_addr_d  = line_align(grant_dc ? dc_addr_i : ic_addr_i);
               mem_we_d    = grant_dc && dc_we_i;
               mem_wdata_d = grant_dc ? dc_wdata_i : '0;
               mem_req_d   = 1'b1;
               busy_d      = 1'b1;
               cnt_d       = '0;
               state_d     = BUSY;
            end
         end
         BUSY: begin
            if (mem_ack_i || cnt_q == CNT_LAST) begin
               // An ack arriving on the last watchdog cycle still counts as success.
               timed_out = !mem_ack_i;
               line      = mem_ack_i ? mem_rdata_i : '0;
               if (owner_q == OWN_DC) begin
                  dc_ack_d   = 1'b1;
                  dc_err_d   = timed_out;
                  dc_rdata_d = line;
               end else begin
                  ic_ack_d   = 1'b1;
                  ic_err_d   = timed_out;
                  ic_rdata_d = line;
               end
               mem_req_d = 1'b0;
               state_d   = RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RESP: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d    = 1'b0;
            mem_req_d = 1'b0;
            state_d   = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         owner_q     <= OWN_IC;
         last_q      <= OWN_DC;
         cnt_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         ic_ack_q    <= 1'b0;
         ic_err_q    <= 1'b0;
         dc_ack_q    <= 1'b0;
         dc_err_q    <= 1'b0;
         ic_rdata_q  <= '0;
         dc_rdata_q  <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         last_q      <= last_d;
         cnt_q       <= cnt_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         ic_ack_q    <= ic_ack_d;
         ic_err_q    <= ic_err_d;
         dc_ack_q    <= dc_ack_d;
         dc_err_q    <= dc_err_d;
         ic_rdata_q  <= ic_rdata_d;
         dc_rdata_q  <= dc_rdata_d;
         busy_q      <= busy_d;
      end
   end

   assign ic_ack_o    = ic_ack_q;
   assign ic_err_o    = ic_err_q;
   assign ic_rdata_o  = ic_rdata_q;
   assign dc_ack_o    = dc_ack_q;
   assign dc_err_o    = dc_err_q;
   assign dc_rdata_o  = dc_rdata_q;
   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: expected memory transactions and cache acks are queued by the stimulus, a monitor checks them.
module tb_cache_mem_arbiter;
   import cache_pkg::*;

   localparam int LW = 128;
   localparam int TO = 8;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          ic_req_i, ic_ack_o, ic_err_o;
   logic [31:0]   ic_addr_i;
   logic [LW-1:0] ic_rdata_o;
   logic          dc_req_i, dc_we_i, dc_ack_o, dc_err_o;
   logic [31:0]   dc_addr_i;
   logic [LW-1:0] dc_wdata_i, dc_rdata_o;
   logic          mem_req_o, mem_we_o, mem_ack_i, busy_o;
   logic [31:0]   mem_addr_o;
   logic [LW-1:0] mem_wdata_o, mem_rdata_i;

   always #5 clk_i = ~clk_i;

   cache_mem_arbiter #(.LINE_W(LW), .TIMEOUT(TO)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_ack_o(ic_ack_o),
      .ic_rdata_o(ic_rdata_o), .ic_err_o(ic_err_o),
      .dc_req_i(dc_req_i), .dc_we_i(dc_we_i), .dc_addr_i(dc_addr_i),
      .dc_wdata_i(dc_wdata_i), .dc_ack_o(dc_ack_o), .dc_rdata_o(dc_rdata_o),
      .dc_err_o(dc_err_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
      .busy_o(busy_o)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk_b(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_w(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [127:0] gen_line(input logic [31:0] a);
      if (a == 32'h0000_1230) return {4{32'hDEAD_BEEF}};
      return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'h1111_1111};
   endfunction

   typedef struct {
      logic [31:0]  addr;
      logic         we;
      logic [127:0] wdata;
   } mem_exp_t;

   typedef struct {
      logic         is_dc;
      logic [127:0] rdata;
      logic         err;
   } rsp_exp_t;

   mem_exp_t mem_q[$];
   rsp_exp_t rsp_q[$];

   // addr is the hand-aligned line address the memory must see
   task automatic expect_xact(input logic is_dc, input logic [31:0] addr, input logic we,
                              input logic [127:0] wdata, input logic err);
      mem_exp_t m;
      rsp_exp_t r;
      m.addr = addr; m.we = we; m.wdata = wdata;
      r.is_dc = is_dc; r.err = err; r.rdata = err ? 128'h0 : gen_line(addr);
      mem_q.push_back(m);
      rsp_q.push_back(r);
   endtask

   // Memory model: acks on the mem_lat-th cycle of mem_req_o (0 = never), stray acks while idle on request.
   int   mem_lat = 2;
   int   mem_cnt = 0;
   logic stray   = 1'b0;

   initial begin
      mem_ack_i   = 1'b0;
      mem_rdata_i = '0;
      forever begin
         @(negedge clk_i);
         #1;
         if (mem_ack_i) begin
            mem_ack_i = 1'b0;
            mem_cnt   = 0;
         end else if (mem_req_o) begin
            mem_cnt++;
            if (mem_lat != 0 && mem_cnt == mem_lat) begin
               mem_ack_i   = 1'b1;
               mem_rdata_i = gen_line(mem_addr_o);
            end
         end else begin
            mem_cnt = 0;
            if (stray) begin
               mem_ack_i   = 1'b1;
               mem_rdata_i = {4{32'hBAD0_BAD0}};
            end
         end
      end
   end

   // Monitor
   logic        prev_req = 1'b0;
   logic        prev_ack_busy = 1'b0;
   int          run = 0;
   int          last_run = 0;
   logic [31:0] cur_addr = '0;
   logic        cur_we = 1'b0;
   mem_exp_t    me;
   rsp_exp_t    re;

   initial begin
      forever begin
         @(negedge clk_i);
         if (!rst_ni) begin
            prev_req      = 1'b0;
            prev_ack_busy = 1'b0;
            run           = 0;
         end else begin
            if (mem_req_o && !prev_req) begin
               chk_b("mem_req_expected", mem_q.size() != 0, 1'b1);
               if (mem_q.size() != 0) begin
                  me = mem_q.pop_front();
                  chk_w("mem_addr", 128'(mem_addr_o), 128'(me.addr));
                  chk_b("mem_we", mem_we_o, me.we);
                  if (me.we) chk_w("mem_wdata", mem_wdata_o, me.wdata);
               end
               cur_addr = mem_addr_o;
               cur_we   = mem_we_o;
               run      = 0;
            end else if (mem_req_o) begin
               chk_w("mem_addr_stable", 128'(mem_addr_o), 128'(cur_addr));
               chk_b("mem_we_stable", mem_we_o, cur_we);
            end
            if (mem_req_o) run++;
            else if (prev_req) last_run = run;

            if (prev_ack_busy) begin
               chk_b("req_drop_after_mem_ack", mem_req_o, 1'b0);
               chk_b("ack_after_mem_ack", ic_ack_o | dc_ack_o, 1'b1);
            end
            if (ic_err_o && !ic_ack_o) chk_b("ic_err_with_ack", ic_ack_o, 1'b1);
            if (dc_err_o && !dc_ack_o) chk_b("dc_err_with_ack", dc_ack_o, 1'b1);

            if (ic_ack_o || dc_ack_o) begin
               chk_b("single_ack", ic_ack_o & dc_ack_o, 1'b0);
               chk_b("ack_expected", rsp_q.size() != 0, 1'b1);
               if (rsp_q.size() != 0) begin
                  re = rsp_q.pop_front();
                  chk_b("ack_owner_dc", dc_ack_o, re.is_dc);
                  chk_w("ack_rdata", re.is_dc ? dc_rdata_o : ic_rdata_o, re.rdata);
                  chk_b("ack_err", re.is_dc ? dc_err_o : ic_err_o, re.err);
                  if (re.err) chk_w("timeout_req_cycles", 128'(last_run), 128'(TO));
               end
            end
            prev_ack_busy = mem_ack_i && mem_req_o;
            prev_req      = mem_req_o;
         end
      end
   end

   task automatic ic_xact(input logic [31:0] addr, input bit hold_extra);
      int n;
      @(negedge clk_i);
      ic_addr_i = addr;
      ic_req_i  = 1'b1;
      n = 0;
      do begin
         @(negedge clk_i);
         n++;
      end while (!ic_ack_o && n < 100);
      chk_b("ic_ack_within_budget", ic_ack_o, 1'b1);
      if (hold_extra) @(negedge clk_i);
      ic_req_i = 1'b0;
   endtask

   task automatic dc_xact(input logic [31:0] addr, input logic we, input logic [127:0] wdata);
      int n;
      @(negedge clk_i);
      dc_addr_i  = addr;
      dc_we_i    = we;
      dc_wdata_i = wdata;
      dc_req_i   = 1'b1;
      n = 0;
      do begin
         @(negedge clk_i);
         n++;
      end while (!dc_ack_o && n < 100);
      chk_b("dc_ack_within_budget", dc_ack_o, 1'b1);
      dc_req_i = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk_b({tag, "_mem_req"}, mem_req_o, 1'b0);
      chk_b({tag, "_mem_we"}, mem_we_o, 1'b0);
      chk_b({tag, "_busy"}, busy_o, 1'b0);
      chk_b({tag, "_acks"}, ic_ack_o | dc_ack_o | ic_err_o | dc_err_o, 1'b0);
      chk_w({tag, "_mem_addr"}, 128'(mem_addr_o), 128'h0);
      chk_w({tag, "_mem_wdata"}, mem_wdata_o, 128'h0);
      chk_w({tag, "_ic_rdata"}, ic_rdata_o, 128'h0);
      chk_w({tag, "_dc_rdata"}, dc_rdata_o, 128'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   localparam logic [127:0] WB_DATA = 128'hCAFE_0001_CAFE_0002_CAFE_0003_CAFE_0004;

   initial begin
      ic_req_i = 1'b0; ic_addr_i = '0;
      dc_req_i = 1'b0; dc_we_i = 1'b0; dc_addr_i = '0; dc_wdata_i = '0;
      repeat (3) @(negedge clk_i);
      chk_all_zero("reset");
      rst_ni = 1'b1;
      repeat (2) @(negedge clk_i);

      // Two back-to-back ties: fresh reset favours the icache each time.
      mem_lat = 2;
      expect_xact(1'b0, 32'h0000_0100, 1'b0, '0, 1'b0);
      expect_xact(1'b1, 32'h0000_0200, 1'b0, '0, 1'b0);
      fork
         ic_xact(32'h0000_0104, 1'b0);
         dc_xact(32'h0000_0208, 1'b0, 128'h0);
      join
      expect_xact(1'b0, 32'h0000_0310, 1'b0, '0, 1'b0);
      expect_xact(1'b1, 32'h0000_0400, 1'b0, '0, 1'b0);
      fork
         ic_xact(32'h0000_031C, 1'b0);
         dc_xact(32'h0000_0400, 1'b0, 128'h0);
      join
      repeat (3) @(negedge clk_i);

      // Icache alone, memory acks in the third BUSY cycle.
      mem_lat = 3;
      expect_xact(1'b0, 32'h0000_1230, 1'b0, '0, 1'b0);
      fork
         ic_xact(32'h0000_1234, 1'b0);
         begin
            @(negedge clk_i);
            @(negedge clk_i);
            chk_b("t1_req_c1", mem_req_o, 1'b1);
            chk_b("t1_busy_c1", busy_o, 1'b1);
            chk_w("t1_addr_c1", 128'(mem_addr_o), 128'h1230);
            chk_b("t1_we_c1", mem_we_o, 1'b0);
            repeat (2) @(negedge clk_i);
            chk_b("t1_no_ack_c3", ic_ack_o, 1'b0);
            @(negedge clk_i);
            chk_b("t1_ack_c4", ic_ack_o, 1'b1);
            chk_b("t1_req_low_c4", mem_req_o, 1'b0);
            chk_w("t1_rdata_c4", ic_rdata_o, {4{32'hDEAD_BEEF}});
            @(negedge clk_i);
            chk_b("t1_idle_c5", busy_o, 1'b0);
         end
      join
      repeat (3) @(negedge clk_i);

      // Writeback then refill from dcache, icache slips in between.
      expect_xact(1'b1, 32'h8000_0040, 1'b1, WB_DATA, 1'b0);
      expect_xact(1'b0, 32'h0000_5000, 1'b0, '0, 1'b0);
      expect_xact(1'b1, 32'h9000_0000, 1'b0, '0, 1'b0);
      fork
         begin
            dc_xact(32'h8000_0040, 1'b1, WB_DATA);
            dc_xact(32'h9000_0000, 1'b0, 128'h0);
         end
         begin
            repeat (2) @(negedge clk_i);
            ic_xact(32'h0000_5004, 1'b0);
         end
      join
      repeat (3) @(negedge clk_i);

      // Watchdog abort, then a normal dcache refill.
      mem_lat = 0;
      expect_xact(1'b1, 32'h0000_2000, 1'b0, '0, 1'b1);
      dc_xact(32'h0000_2008, 1'b0, 128'h0);
      mem_lat = 2;
      expect_xact(1'b1, 32'h0000_2100, 1'b0, '0, 1'b0);
      dc_xact(32'h0000_2100, 1'b0, 128'h0);
      repeat (3) @(negedge clk_i);

      // Request held through the ack cycle, then stray memory acks while idle.
      mem_lat = 1;
      expect_xact(1'b0, 32'h0000_7000, 1'b0, '0, 1'b0);
      ic_xact(32'h0000_7000, 1'b1);
      repeat (2) @(negedge clk_i);
      chk_b("hold_no_regrant", busy_o, 1'b0);
      stray = 1'b1;
      repeat (3) begin
         @(negedge clk_i);
         chk_b("stray_busy", busy_o, 1'b0);
         chk_b("stray_no_ack", ic_ack_o | dc_ack_o, 1'b0);
      end
      stray = 1'b0;
      repeat (3) @(negedge clk_i);

      // Reset in the middle of an icache transaction loses it; post-reset tie goes to icache.
      mem_lat = 0;
      mem_q.push_back('{32'h0000_8880, 1'b0, 128'h0});
      @(negedge clk_i);
      ic_addr_i = 32'h0000_8884;
      ic_req_i  = 1'b1;
      repeat (3) @(negedge clk_i);
      rst_ni = 1'b0;
      #1;
      chk_all_zero("midreset");
      ic_req_i = 1'b0;
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (2) @(negedge clk_i);
      mem_lat = 2;
      expect_xact(1'b0, 32'h0000_A000, 1'b0, '0, 1'b0);
      expect_xact(1'b1, 32'h0000_B000, 1'b0, '0, 1'b0);
      fork
         ic_xact(32'h0000_A000, 1'b0);
         dc_xact(32'h0000_B000, 1'b0, 128'h0);
      join
      repeat (4) @(negedge clk_i);

      chk_w("mem_queue_drained", 128'(mem_q.size()), 128'h0);
      chk_w("rsp_queue_drained", 128'(rsp_q.size()), 128'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
